// File: rtl/conv_ctrl.sv
// conv_ctrl: loads a filter and pixel window into register banks, lets the external conv datapath settle, then holds its result for the consumer
module conv_ctrl #(
   parameter int SIZE       = 7,
   parameter int N          = 32,
   parameter int SETTLE_CYC = 2
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   cfg_load,
   input  logic [N-1:0]           cfg_bias,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [N-1:0]           in_data,
   output logic [SIZE*SIZE*N-1:0] conv_filter,
   output logic [SIZE*SIZE*N-1:0] conv_input,
   output logic [N-1:0]           conv_bias,
   input  logic [N-1:0]           conv_result,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [N-1:0]           out_data,
   output logic                   filter_ok,
   output logic                   busy
);
   localparam int WORDS = SIZE * SIZE;
   localparam int IW = WORDS > 1 ? $clog2(WORDS) : 1;
   localparam logic [IW-1:0] LAST = IW'(WORDS - 1);
   localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYC - 1);

   typedef enum logic [2:0] {IDLE, LOAD_F, LOAD_X, SETTLE, HOLD} state_t;

   state_t        r_state, w_next;
   logic [IW-1:0] r_idx;
   logic [3:0]    r_cnt;
   logic [N-1:0]  r_filt [WORDS];
   logic [N-1:0]  r_win [WORDS];
   logic [N-1:0]  r_bias, r_out_data;
   logic          r_out_valid, r_filter_ok;
   logic          w_in_ready, w_accept, w_last, w_settled;

   assign w_in_ready = r_state == LOAD_F || r_state == LOAD_X;
   assign w_accept   = w_in_ready && in_valid;
   assign w_last     = r_idx == LAST;
   assign w_settled  = r_cnt == SETTLE_LAST;

   assign in_ready  = w_in_ready;
   assign conv_bias = r_bias;
   assign out_valid = r_out_valid;
   assign out_data  = r_out_data;
   assign filter_ok = r_filter_ok;
   assign busy      = r_state != IDLE;

   genvar g;
   generate
      for (g = 0; g < WORDS; g++) begin : g_pack
         assign conv_filter[g*N +: N] = r_filt[g];
         assign conv_input[g*N +: N]  = r_win[g];
      end
   endgenerate

   // next state: cfg_load wins in IDLE; a window starts only once a full filter is present
   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    w_next = cfg_load ? LOAD_F : (in_valid && r_filter_ok) ? LOAD_X : IDLE;
         LOAD_F:  w_next = (w_accept && w_last) ? IDLE : LOAD_F;
         LOAD_X:  w_next = (w_accept && w_last) ? SETTLE : LOAD_X;
         SETTLE:  w_next = w_settled ? HOLD : SETTLE;
         HOLD:    w_next = out_ready ? IDLE : HOLD;
         default: w_next = IDLE;
      endcase
   end

   // state register, load index, settle counter, bias and result capture
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= IDLE;
         r_idx       <= '0;
         r_cnt       <= '0;
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
         r_filter_ok <= 1'b0;
         r_bias      <= '0;
      end else begin
         r_state <= w_next;
         if (r_state == IDLE && cfg_load) begin
            r_bias      <= cfg_bias;
            r_filter_ok <= 1'b0;
            r_idx       <= '0;
         end else if (r_state == IDLE && in_valid && r_filter_ok) begin
            r_idx <= '0;
         end
         if (w_accept) r_idx <= w_last ? '0 : r_idx + IW'(1);
         if (w_accept && w_last && r_state == LOAD_F) r_filter_ok <= 1'b1;
         if (w_accept && w_last && r_state == LOAD_X) r_cnt <= '0;
         if (r_state == SETTLE) r_cnt <= r_cnt + 4'd1;
         if (r_state == SETTLE && w_settled) begin
            r_out_data  <= conv_result;
            r_out_valid <= 1'b1;
         end
         if (r_state == HOLD && out_ready) r_out_valid <= 1'b0;
      end
   end

   // filter and window banks; each is written only while its own load state accepts a word
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < WORDS; i++) begin
            r_filt[i] <= '0;
            r_win[i]  <= '0;
         end
      end else if (w_accept) begin
         if (r_state == LOAD_F) r_filt[r_idx] <= in_data;
         else r_win[r_idx] <= in_data;
      end
   end
endmodule

// File: tb/tb_conv_ctrl.sv
// tb_conv_ctrl: directed vector bench for conv_ctrl with a Q15.16 multiply-accumulate datapath model attached
module tb_conv_ctrl;
   localparam int W = 49;
   localparam int N = 32;

   logic          clk, rst, cfg_load, in_valid, in_ready, out_valid, out_ready, filter_ok, busy;
   logic [N-1:0]  cfg_bias, in_data, conv_bias, conv_result, out_data;
   logic [W*N-1:0] conv_filter, conv_input;

   int n_checks = 0;
   int n_fail = 0;

   logic [31:0] f [W];
   logic [31:0] x [W];

   typedef struct {
      logic [31:0] tap;
      logic [31:0] pix;
      logic [31:0] bias;
      logic [31:0] exp;
   } vec_t;
   vec_t vecs [5];

   conv_ctrl dut (
      .clk(clk), .rst(rst), .cfg_load(cfg_load), .cfg_bias(cfg_bias),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .conv_filter(conv_filter), .conv_input(conv_input), .conv_bias(conv_bias),
      .conv_result(conv_result), .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .filter_ok(filter_ok), .busy(busy)
   );

   initial clk = 0;
   always #5 clk = ~clk;

   // reference conv datapath: sum of (tap*pixel)>>16 plus bias, truncated to 32 bits
   always_comb begin : dp
      logic signed [63:0] acc, p;
      logic [31:0] a, b;
      acc = {{32{conv_bias[31]}}, conv_bias};
      for (int i = 0; i < W; i++) begin
         a = conv_filter[i*N +: N];
         b = conv_input[i*N +: N];
         p = {{32{a[31]}}, a} * {{32{b[31]}}, b};
         acc = acc + (p >>> 16);
      end
      conv_result = acc[31:0];
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic push(input logic [31:0] w);
      int n = 0;
      in_valid = 1;
      in_data = w;
      while (!in_ready && n < 8) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) chk("push_ready_timeout", {63'd0, in_ready}, 64'd1);
      @(posedge clk);
      #1;
      in_valid = 0;
   endtask

   task automatic load_filter(input logic [31:0] bias);
      cfg_load = 1;
      cfg_bias = bias;
      @(posedge clk);
      #1;
      cfg_load = 0;
      chk("lf_busy", {63'd0, busy}, 64'd1);
      chk("lf_fok_cleared", {63'd0, filter_ok}, 64'd0);
      for (int i = 0; i < W; i++) push(f[i]);
      chk("lf_fok_set", {63'd0, filter_ok}, 64'd1);
      chk("lf_idle", {63'd0, busy}, 64'd0);
      chk("lf_bias", {32'd0, conv_bias}, {32'd0, bias});
   endtask

   task automatic wait_result(input logic [31:0] exp);
      int n = 0;
      while (!out_valid && n < 10) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk("latency", 64'(n), 64'd2);
      chk("out_data", {32'd0, out_data}, {32'd0, exp});
   endtask

   task automatic release_out(input int hold, input logic [31:0] exp);
      for (int k = 0; k < hold; k++) begin
         @(posedge clk);
         #1;
         chk("hold_valid", {63'd0, out_valid}, 64'd1);
         chk("hold_data", {32'd0, out_data}, {32'd0, exp});
      end
      out_ready = 1;
      @(posedge clk);
      #1;
      out_ready = 0;
      chk("rel_valid", {63'd0, out_valid}, 64'd0);
      chk("rel_idle", {63'd0, busy}, 64'd0);
   endtask

   task automatic run_window(input logic [31:0] exp, input int gaps, input int hold);
      for (int i = 0; i < W; i++) begin
         push(x[i]);
         if (gaps != 0 && i < W - 1 && (i % 3) != 0) begin
            repeat (i % 3) @(posedge clk);
            #1;
            if (i == 1) chk("gap_ready_held", {63'd0, in_ready}, 64'd1);
         end
      end
      wait_result(exp);
      release_out(hold, exp);
   endtask

   task automatic chk_reset_outputs();
      chk("rst_in_ready", {63'd0, in_ready}, 64'd0);
      chk("rst_busy", {63'd0, busy}, 64'd0);
      chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
      chk("rst_out_data", {32'd0, out_data}, 64'd0);
      chk("rst_filter_ok", {63'd0, filter_ok}, 64'd0);
      chk("rst_conv_bias", {32'd0, conv_bias}, 64'd0);
      chk("rst_filter_zero", {63'd0, conv_filter == '0}, 64'd1);
      chk("rst_input_zero", {63'd0, conv_input == '0}, 64'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0] = '{32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 32'h0031_0000};
      vecs[1] = '{32'h0002_0000, 32'h0000_8000, 32'h0001_0000, 32'h0032_0000};
      vecs[2] = '{32'h0001_0000, 32'hFFFF_0000, 32'h0000_0000, 32'hFFCF_0000};
      vecs[3] = '{32'h0000_0000, 32'h0001_2345, 32'h0007_0000, 32'h0007_0000};
      vecs[4] = '{32'h0000_4000, 32'h0004_0000, 32'hFFFF_8000, 32'h0030_8000};
      rst = 1; cfg_load = 0; cfg_bias = 0; in_valid = 0; in_data = 0; out_ready = 0;
      repeat (2) @(posedge clk);
      #1;
      rst = 0;
      chk_reset_outputs();
      in_valid = 1;
      in_data = 32'h0001_0000;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         chk("nofilt_ready", {63'd0, in_ready}, 64'd0);
         chk("nofilt_busy", {63'd0, busy}, 64'd0);
      end
      chk("nofilt_out_valid", {63'd0, out_valid}, 64'd0);
      @(posedge clk);
      #1;
      in_valid = 0;
      for (int v = 0; v < 5; v++) begin
         for (int i = 0; i < W; i++) begin
            f[i] = vecs[v].tap;
            x[i] = vecs[v].pix;
         end
         load_filter(vecs[v].bias);
         run_window(vecs[v].exp, 0, 0);
      end
      for (int i = 0; i < W; i++) begin
         f[i] = 32'h0001_0000;
         x[i] = 32'h0001_0000;
      end
      load_filter(32'h0);
      run_window(32'h0031_0000, 1, 5);
      for (int i = 0; i < W; i++) begin
         f[i] = 0;
         x[i] = 32'(i + 1) << 16;
      end
      f[0] = 32'h0003_0000;
      f[W-1] = 32'h0002_0000;
      load_filter(32'h0);
      run_window(32'h0065_0000, 0, 0);
      chk("filter_word0", {32'd0, conv_filter[0 +: N]}, 64'h0003_0000);
      chk("filter_word48", {32'd0, conv_filter[48*N +: N]}, 64'h0002_0000);
      chk("input_word48", {32'd0, conv_input[48*N +: N]}, 64'h0031_0000);
      push(x[0]);
      cfg_load = 1;
      cfg_bias = 32'h0000_7777;
      for (int i = 1; i < W; i++) push(x[i]);
      wait_result(32'h0065_0000);
      repeat (2) begin
         @(posedge clk);
         #1;
         chk("cfg_hold_busy", {63'd0, busy}, 64'd1);
         chk("cfg_hold_valid", {63'd0, out_valid}, 64'd1);
      end
      cfg_load = 0;
      chk("cfg_ign_fok", {63'd0, filter_ok}, 64'd1);
      chk("cfg_ign_bias", {32'd0, conv_bias}, 64'd0);
      chk("cfg_ign_word0", {32'd0, conv_filter[0 +: N]}, 64'h0003_0000);
      release_out(0, 32'h0065_0000);
      cfg_load = 1;
      cfg_bias = 32'h0005_0000;
      in_valid = 1;
      in_data = 32'h0001_0000;
      @(posedge clk);
      #1;
      cfg_load = 0;
      in_valid = 0;
      chk("prio_busy", {63'd0, busy}, 64'd1);
      chk("prio_fok", {63'd0, filter_ok}, 64'd0);
      chk("prio_bias", {32'd0, conv_bias}, 64'h0005_0000);
      chk("prio_ready", {63'd0, in_ready}, 64'd1);
      for (int i = 0; i < W; i++) begin
         f[i] = 32'h0001_0000;
         x[i] = 32'h0001_0000;
      end
      for (int i = 0; i < W; i++) push(f[i]);
      chk("prio_fok_set", {63'd0, filter_ok}, 64'd1);
      run_window(32'h0036_0000, 0, 0);
      for (int i = 0; i < 20; i++) push(x[i]);
      rst = 1;
      @(posedge clk);
      #1;
      rst = 0;
      chk_reset_outputs();
      in_valid = 1;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         chk("post_rst_ready", {63'd0, in_ready}, 64'd0);
         chk("post_rst_busy", {63'd0, busy}, 64'd0);
      end
      in_valid = 0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
